// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester/SPI-master signal bundle for spi_arbiter.
//   req       requester -> arbiter  level requests, one bit per requester
//   din_flat  requester -> arbiter  frame data, requester i at [i*DW +: DW]
//   gnt       arbiter -> requester  one-hot grant
//   done/err  arbiter -> requester  completion / timeout-abort pulses
//   spi_newd  arbiter -> SPI master new-data strobe
//   spi_din   arbiter -> SPI master frame data
//   spi_cs    SPI master -> arbiter active-low chip select (async to clk)
//   busy      arbiter status, high outside IDLE
// modport slave is the arbiter side, modport master the requester/SPI side.
interface spi_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int DW    = 12
);
   logic [N_REQ-1:0]    req;
   logic [N_REQ*DW-1:0] din_flat;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    done;
   logic [N_REQ-1:0]    err;
   logic                spi_newd;
   logic [DW-1:0]       spi_din;
   logic                spi_cs;
   logic                busy;

   modport slave (
      input  req, din_flat, spi_cs,
      output gnt, done, err, spi_newd, spi_din, busy
   );

   modport master (
      output req, din_flat, spi_cs,
      input  gnt, done, err, spi_newd, spi_din, busy
   );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one SPI master between N_REQ
// requesters, with a per-phase timeout abort.
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    spi_arbiter_if.slave (req, din_flat, spi_cs in; gnt, done, err,
//          spi_newd, spi_din, busy out)
module spi_arbiter #(
   parameter int N_REQ = 4,
   parameter int DW    = 12,
   parameter int TMO   = 4095
) (
   input  logic          clk,
   input  logic          rst_n,
   spi_arbiter_if.slave  bus
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

   typedef enum logic [2:0] {IDLE, LAUNCH, XFER, DONE, ERR} state_t;

   state_t        state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] own;
   logic [CW-1:0] cnt;
   logic          cs_m;
   logic          cs_s;

   logic          found;
   logic [PW-1:0] win;
   int unsigned   idx;

   // First set request at or above ptr, wrapping.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      idx   = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(ptr) + k) % 32'(N_REQ);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
      return (w == PW'(N_REQ - 1)) ? '0 : w + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_m         <= 1'b1;
         cs_s         <= 1'b1;
         state        <= IDLE;
         ptr          <= '0;
         own          <= '0;
         cnt          <= '0;
         bus.gnt      <= '0;
         bus.done     <= '0;
         bus.err      <= '0;
         bus.spi_newd <= 1'b0;
         bus.spi_din  <= '0;
         bus.busy     <= 1'b0;
      end else begin
         cs_m <= bus.spi_cs;
         cs_s <= cs_m;
         unique case (state)
            IDLE: begin
               if (found) begin
                  own          <= win;
                  bus.gnt      <= N_REQ'(1) << win;
                  bus.spi_din  <= bus.din_flat[win*DW +: DW];
                  bus.spi_newd <= 1'b1;
                  bus.busy     <= 1'b1;
                  cnt          <= '0;
                  state        <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (!cs_s) begin
                  bus.spi_newd <= 1'b0;
                  cnt          <= '0;
                  state        <= XFER;
               end else if (cnt == CW'(TMO - 1)) begin
                  bus.spi_newd <= 1'b0;
                  bus.err      <= N_REQ'(1) << own;
                  cnt          <= CW'(TMO);
                  state        <= ERR;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            XFER: begin
               if (cs_s) begin
                  bus.done <= N_REQ'(1) << own;
                  state    <= DONE;
               end else if (cnt == CW'(TMO - 1)) begin
                  bus.err <= N_REQ'(1) << own;
                  cnt     <= CW'(TMO);
                  state   <= ERR;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE, ERR: begin
               bus.done     <= '0;
               bus.err      <= '0;
               bus.gnt      <= '0;
               bus.spi_newd <= 1'b0;
               bus.busy     <= 1'b0;
               ptr          <= next_ptr(own);
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed self-checking bench for spi_arbiter (N_REQ=4,
// DW=12, TMO=40). A simple chip-select model drops cs a few cycles after
// newd and raises it after the frame; grant order, data capture, timeout
// and reset abort are checked against hand-computed values.
module tb_spi_arbiter;
   localparam int TMO = 40;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   localparam logic [11:0] D0 = 12'hA5C;
   localparam logic [11:0] D1 = 12'h3C7;
   localparam logic [11:0] D2 = 12'h5A1;
   localparam logic [11:0] D3 = 12'hF0E;

   always #5 clk = ~clk;

   spi_arbiter_if #(.N_REQ(4), .DW(12)) bus ();

   spi_arbiter #(.N_REQ(4), .DW(12), .TMO(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: normal frame, mode 1: cs never drops (timeout),
   // mode 2: din_flat and req disturbed mid-XFER.
   task automatic xfer(input logic [3:0] exp_g, input logic [11:0] exp_d,
                       input logic [3:0] req_after, input int mode);
      int t;
      for (t = 0; t < 50 && bus.gnt == 4'b0; t++) @(negedge clk);
      check("gnt_wait", 32'(t < 50), 32'd1);
      check("gnt", 32'(bus.gnt), 32'(exp_g));
      check("spi_din", 32'(bus.spi_din), 32'(exp_d));
      check("newd_launch", 32'(bus.spi_newd), 32'd1);
      check("busy", 32'(bus.busy), 32'd1);
      bus.req = req_after;
      if (mode == 1) begin
         for (t = 0; t < TMO + 10 && bus.err == 4'b0; t++) @(negedge clk);
         check("tmo_cycles", 32'(t), 32'(TMO));
         check("err", 32'(bus.err), 32'(exp_g));
         check("done_on_err", 32'(bus.done), 32'd0);
         check("newd_err", 32'(bus.spi_newd), 32'd0);
         check("gnt_err", 32'(bus.gnt), 32'(exp_g));
         @(negedge clk);
         check("err_pulse", 32'(bus.err), 32'd0);
      end else begin
         repeat (3) @(negedge clk);
         bus.spi_cs = 1'b0;
         for (t = 0; t < 10 && bus.spi_newd; t++) @(negedge clk);
         check("newd_clr", 32'(t < 10), 32'd1);
         check("gnt_xfer", 32'(bus.gnt), 32'(exp_g));
         repeat (12) @(negedge clk);
         if (mode == 2) begin
            bus.din_flat = '1;
            bus.req      = 4'b0;
         end
         repeat (12) @(negedge clk);
         if (mode == 2) check("din_hold", 32'(bus.spi_din), 32'(exp_d));
         bus.spi_cs = 1'b1;
         for (t = 0; t < 10 && bus.done == 4'b0; t++) @(negedge clk);
         check("done", 32'(bus.done), 32'(exp_g));
         check("gnt_done", 32'(bus.gnt), 32'(exp_g));
         @(negedge clk);
         check("done_pulse", 32'(bus.done), 32'd0);
      end
      check("gnt_clr", 32'(bus.gnt), 32'd0);
      check("busy_clr", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int t;
      rst_n        = 1'b0;
      bus.spi_cs   = 1'b1;
      bus.req      = 4'b0;
      bus.din_flat = {D3, D2, D1, D0};
      #1;
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_newd", 32'(bus.spi_newd), 32'd0);
      check("rst_din", 32'(bus.spi_din), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_gnt", 32'(bus.gnt), 32'd0);

      // all requesting: 0,1,2,3 then 0 again
      bus.req = 4'b1111;
      xfer(4'b0001, D0, 4'b1111, 0);
      xfer(4'b0010, D1, 4'b1111, 0);
      xfer(4'b0100, D2, 4'b1111, 0);
      xfer(4'b1000, D3, 4'b1111, 0);
      xfer(4'b0001, D0, 4'b0000, 0);

      // single requester 0 (ptr=1 wraps to 0)
      bus.req = 4'b0001;
      xfer(4'b0001, D0, 4'b0000, 0);
      // requester 1 moves ptr to 2, then 1001 -> 3 first, then 0
      bus.req = 4'b0010;
      xfer(4'b0010, D1, 4'b0000, 0);
      bus.req = 4'b1001;
      xfer(4'b1000, D3, 4'b0001, 0);
      xfer(4'b0001, D0, 4'b0000, 0);

      // timeout on requester 2; ptr then 3, so 0101 picks 0
      bus.req = 4'b0100;
      xfer(4'b0100, D2, 4'b0000, 1);
      bus.req = 4'b0101;
      xfer(4'b0001, D0, 4'b0000, 0);

      // reset during XFER
      bus.req = 4'b0100;
      for (t = 0; t < 50 && bus.gnt == 4'b0; t++) @(negedge clk);
      check("rx_gnt", 32'(bus.gnt), 32'b0100);
      bus.req = 4'b0;
      repeat (3) @(negedge clk);
      bus.spi_cs = 1'b0;
      repeat (8) @(negedge clk);
      check("rx_in_xfer", 32'({bus.busy, bus.spi_newd}), 32'b10);
      rst_n = 1'b0;
      #1;
      check("rx_gnt0", 32'(bus.gnt), 32'd0);
      check("rx_busy0", 32'(bus.busy), 32'd0);
      check("rx_din0", 32'(bus.spi_din), 32'd0);
      check("rx_done0", 32'(bus.done), 32'd0);
      @(negedge clk);
      bus.spi_cs = 1'b1;
      rst_n      = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rx_no_done", 32'({bus.done, bus.err}), 32'd0);
      end
      bus.req = 4'b1001;
      xfer(4'b0001, D0, 4'b0000, 0);

      // din_flat and req disturbed mid-XFER
      bus.req = 4'b0010;
      xfer(4'b0010, D1, 4'b0010, 2);
      bus.din_flat = {D3, D2, D1, D0};

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one SPI master.
REQ-002 Parameter DW, default 12, SPI frame width in bits.
REQ-003 Parameter TMO, default 4095, clk cycles allowed per transaction phase before abort.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-requester level request; bit i high means requester i has a frame pending.
REQ-007 din_flat  input  N_REQ*DW  requester data; bits [i*DW +: DW] belong to requester i.
REQ-008 gnt  output  N_REQ  one-hot grant; high from grant cycle through the DONE or ERR cycle.
REQ-009 done  output  N_REQ  one-cycle pulse on bit i when requester i's frame has completed.
REQ-010 err  output  N_REQ  one-cycle pulse on bit i when requester i's frame was aborted by timeout.
REQ-011 spi_newd  output  1  new-data strobe to the SPI master.
REQ-012 spi_din  output  DW  frame data to the SPI master.
REQ-013 spi_cs  input  1  active-low chip select from the SPI master; asynchronous to clk.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 spi_cs shall pass through a 2-flop synchronizer (reset value 1) before use; cs_s denotes the synchronized value.
REQ-016 FSM states: IDLE, LAUNCH, XFER, DONE, ERR.
REQ-017 IDLE: if any req bit is set, select winner w by round-robin, searching upward from pointer ptr and wrapping from N_REQ-1 to 0; next cycle gnt[w]=1, spi_din=din_flat[w] captured, state=LAUNCH.
REQ-018 spi_din shall hold the captured value until the next grant; later changes to din_flat shall not affect it.
REQ-019 LAUNCH: spi_newd=1; when cs_s==0, clear spi_newd and enter XFER on the next cycle.
REQ-020 XFER: spi_newd=0; when cs_s==1, enter DONE.
REQ-021 DONE: done[w]=1 for exactly one cycle; gnt cleared; ptr=(w+1) mod N_REQ; next state IDLE.
REQ-022 Timeout counter: cleared on entering LAUNCH and on entering XFER; increments each cycle spent in those states; reaching TMO enters ERR.
REQ-023 ERR: err[w]=1 for one cycle, spi_newd=0, gnt cleared, ptr=(w+1) mod N_REQ; next state IDLE.
REQ-024 A req bit deasserted while its owner is granted shall be ignored; the transaction runs to DONE or ERR.
REQ-025 A new grant shall not be issued in the same cycle as DONE or ERR; the minimum gap between grants is one IDLE cycle.
REQ-026 Only the requester at ptr, or the first set bit above it with wrap, wins; no requester waits more than N_REQ-1 grants.
REQ-027 If all req bits are zero in IDLE, the FSM shall stay in IDLE with all outputs at reset values except ptr and spi_din, which are held.
REQ-028 The counter width shall be ceil(log2(TMO+1)) bits; the counter shall not wrap.

Reset
REQ-029 While rst_n==0: state=IDLE, ptr=0, gnt=0, done=0, err=0, spi_newd=0, spi_din=0, busy=0, counter=0, synchronizer=1 -- all applied immediately and asynchronously.
REQ-030 Reset mid-transaction shall abort without issuing done or err; after release, arbitration restarts at requester 0.

Verification
REQ-031 req=4'b0001, din0=12'hA5C, cs model drops 3 cycles after newd and rises after 24 sclk edges -> gnt=0001, spi_din=A5C, newd cleared after cs low, done=0001 for one cycle.
REQ-032 req=4'b1111 held for 4 transactions -> grants in order 0,1,2,3, then 0 again on the 5th.
REQ-033 ptr=2, req=4'b1001 -> requester 3 granted first, then requester 0.
REQ-034 cs held high by the model after newd -> after TMO cycles in LAUNCH: err[w]=1 for one cycle, newd=0, state IDLE, ptr advanced.
REQ-035 rst_n pulsed low during XFER with req=0100 -> outputs zero in the same cycle, no done pulse, next grant is to the lowest requesting index at or above 0.
REQ-036 din_flat changed and req dropped mid-XFER -> spi_din unchanged, transaction completes with done.
